dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU memory stage and a debug/loader host port. It sits between the memory module's access logic and the data RAM array. It grants one access per `CLK` cycle using round-robin priority, so the testbench host can preload or inspect data memory (e.g. addresses 50/51) while the CPU runs. It routes one-cycle-latency read data back to the port that issued the read and stalls the losing requester.

## Interface
Parameters:
- `ADDR_W`, 8: data memory address width.
- `DATA_W`, 16: data word width.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU requests an access this cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_gnt`  out  1  CPU access accepted this cycle (combinational).
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  CPU read data valid (registered).
- `cpu_rdata`  out  DATA_W  CPU read data.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same meanings for the host port.
- `dbg_lock`  in  1  while high with `dbg_req`, the host keeps priority over the CPU.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read strobe.

## Operation
- Priority pointer `prio` has two values:
  - `P_CPU`: CPU wins ties.
  - `P_DBG`: host wins ties.
- Grant rules in each cycle:
  - Only one requester asserts req: that requester is granted.
  - Both request and `dbg_lock`=1: host is granted.
  - Both request and `dbg_lock`=0: the `prio` owner is granted.
  - No requests: no grant, and `mem_en`=0.
- Pointer update, only after a cycle in which both requested and `dbg_lock`=0: `prio` moves to the loser. Otherwise `prio` holds.
- The granted port's `we`, `addr` and `wdata` are muxed onto `mem_*`, and `mem_en`=1.
- Read-return tracking:
  - Registered tag `rd_owner` ∈ {NONE, CPU, DBG} is set on a granted read and cleared otherwise.
  - Next cycle: `mem_rdata` is captured into the owner's `rdata` register, and that owner's `rvalid` pulses for 1 cycle.
  - `rdata` holds its value until the next return to that port.
- A granted write produces no `rvalid`.
- A stalled requester must hold req, we, addr and wdata stable until granted. The arbiter does not buffer requests.
- Read and write to the same address from different ports in consecutive cycles are served in grant order. There is no forwarding beyond what the RAM itself does.

## Timing
- Grant latency: 0 cycles. `gnt` and `mem_*` are combinational from req, `dbg_lock` and `prio`.
- Read latency: read granted in cycle N gives `rvalid` and `rdata` in cycle N+1.
- Back-to-back reads from one port: one per cycle, with `rvalid` high continuously.
- Fairness: with both ports requesting and lock low, grants strictly alternate. Worst-case CPU wait is 1 cycle when unlocked and unbounded while `dbg_lock` is held.
- Reset values:
  - `prio`=`P_CPU`, `rd_owner`=NONE.
  - `cpu_rvalid`=`dbg_rvalid`=0, `cpu_rdata`=`dbg_rdata`=0.
  - Combinational outputs follow the inputs, except that `mem_en` and all `gnt` outputs are forced to 0 while `rst`=1.
- Reset mid-operation: if reset asserts while a read is outstanding, the return is dropped and no `rvalid` appears after reset deasserts.
- Simultaneous grant and return: a new grant in cycle N+1 is independent of the return for cycle N, so full throughput is maintained.

## Test plan
- Reset: assert `rst` with both ports requesting. Required: all `gnt`=0, `mem_en`=0, `rvalid`=0, `rdata`=0. After release, the CPU wins the first tie.
- Single CPU read: preload mem[50]=1, `cpu_req`=1, `cpu_we`=0, `cpu_addr`=50. Required: `cpu_gnt`=1 the same cycle; next cycle `cpu_rvalid`=1 and `cpu_rdata`=1; `dbg_rvalid` stays 0.
- Round-robin contention: both ports read continuously for 4 cycles, CPU at addr 50 and host at addr 51 (=100). Required:
  - Grants go CPU, DBG, CPU, DBG.
  - Returns alternate CPU=1 and DBG=100, each one cycle after its grant.
  - `cpu_stall`=1 exactly in cycles 2 and 4.
- Lock: `dbg_lock`=1 with both requesting for 3 cycles. Required: DBG is granted all 3 cycles and `cpu_stall`=1 throughout. After lock drops, the next tie goes to `prio`, which is unchanged.
- Write then read: host writes 624 to addr 10, then the CPU reads addr 10. Required: one `mem_we` pulse with `mem_wdata`=624, then `cpu_rdata`=624 with `cpu_rvalid` one cycle after the CPU grant.
- Reset during read: CPU read granted, then `rst` pulsed before the next edge. Required: no `cpu_rvalid` after reset deasserts, and `rd_owner` is NONE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data RAM between the CPU memory
// stage and a debug/loader host port, with one-cycle read-return routing.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              prio_o,
  output logic [1:0]        rd_owner_o
);

  typedef enum logic {P_CPU = 1'b0, P_DBG = 1'b1} prio_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DBG = 2'd2} owner_e;

  prio_e             prio_q, prio_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_win, dbg_win;

  // Handshake: a request is accepted in the same cycle its gnt is high; a
  // stalled requester keeps req/we/addr/wdata stable until gnt, nothing is buffered.
  always_comb begin
    cpu_win = cpu_req & ~(dbg_req & (dbg_lock | (prio_q == P_DBG)));
    dbg_win = dbg_req & ~cpu_win;
    cpu_gnt = cpu_win & ~rst;
    dbg_gnt = dbg_win & ~rst;
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_en = cpu_gnt | dbg_gnt;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we = cpu_we;
      mem_addr = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we = dbg_we;
      mem_addr = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Next-state: priority moves to the loser only after an unlocked tie.
  always_comb begin
    prio_d = prio_q;
    rd_owner_d = OWN_NONE;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    if (cpu_req && dbg_req && !dbg_lock) begin
      prio_d = cpu_gnt ? P_DBG : P_CPU;
    end
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      rd_owner_d = OWN_DBG;
    end
    if (rd_owner_q == OWN_CPU) begin
      cpu_rdata_d = mem_rdata;
    end
    if (rd_owner_q == OWN_DBG) begin
      dbg_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      prio_q <= P_CPU;
      rd_owner_q <= OWN_NONE;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      prio_q <= prio_d;
      rd_owner_q <= rd_owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Return data is shown in the cycle it arrives, then held in the port register.
  always_comb begin
    cpu_rvalid = (rd_owner_q == OWN_CPU);
    dbg_rvalid = (rd_owner_q == OWN_DBG);
    cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;
    prio_o = prio_q;
    rd_owner_o = rd_owner_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single read, round robin, lock,
// write-then-read and reset during an outstanding read, against a behavioural RAM.
module tb_dmem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              CLK;
  logic              rst;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              prio_o;
  logic [1:0]        rd_owner_o;

  int n_checks = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .prio_o(prio_o), .rd_owner_o(rd_owner_o)
  );

  // Clock / reset-free RAM model
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    ram[50] = 16'd1;
    ram[51] = 16'd100;
    mem_rdata = '0;
  end

  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Round-robin expectations for 4 contended cycles
  logic rr_cg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic rr_crv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic rr_drv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd50; cpu_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd51; dbg_wdata = '0;
    dbg_lock = 1'b0;
    #12;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_prio", prio_o, 0);
    check("rst_rd_owner", rd_owner_o, 0);

    tick(); rst = 1'b0; #1;
    check("tie_first_cpu_gnt", cpu_gnt, 1);
    check("tie_first_dbg_gnt", dbg_gnt, 0);
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Single CPU read of addr 50
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd50; #1;
    check("rd_cpu_gnt", cpu_gnt, 1);
    check("rd_cpu_stall", cpu_stall, 0);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 50);
    tick(); cpu_req = 1'b0; #1;
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 1);
    check("rd_dbg_rvalid", dbg_rvalid, 0);
    check("rd_idle_mem_en", mem_en, 0);
    tick(); #1;
    check("rd_rvalid_drop", cpu_rvalid, 0);
    check("rd_rdata_hold", cpu_rdata, 1);

    // Round robin: both read continuously
    tick(); cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 8'd50; dbg_addr = 8'd51;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      check($sformatf("rr%0d_cpu_gnt", i), cpu_gnt, rr_cg[i]);
      check($sformatf("rr%0d_dbg_gnt", i), dbg_gnt, !rr_cg[i]);
      check($sformatf("rr%0d_cpu_stall", i), cpu_stall, !rr_cg[i]);
      check($sformatf("rr%0d_cpu_rvalid", i), cpu_rvalid, rr_crv[i]);
      check($sformatf("rr%0d_dbg_rvalid", i), dbg_rvalid, rr_drv[i]);
      if (rr_crv[i]) check($sformatf("rr%0d_cpu_rdata", i), cpu_rdata, 1);
      if (rr_drv[i]) check($sformatf("rr%0d_dbg_rdata", i), dbg_rdata, 100);
    end
    // Fifth tie goes back to CPU, leaving prio at DBG
    tick(); #1;
    check("rr4_cpu_gnt", cpu_gnt, 1);
    check("rr4_dbg_rvalid", dbg_rvalid, 1);
    check("rr4_dbg_rdata", dbg_rdata, 100);

    // Lock: host keeps priority, prio must not move
    tick(); dbg_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      check($sformatf("lk%0d_dbg_gnt", i), dbg_gnt, 1);
      check($sformatf("lk%0d_cpu_gnt", i), cpu_gnt, 0);
      check($sformatf("lk%0d_cpu_stall", i), cpu_stall, 1);
      check($sformatf("lk%0d_prio", i), prio_o, 1);
      check($sformatf("lk%0d_dbg_rvalid", i), dbg_rvalid, (i > 0) ? 1 : 0);
    end
    tick(); dbg_lock = 1'b0; #1;
    check("unlk_dbg_gnt", dbg_gnt, 1);
    check("unlk_cpu_stall", cpu_stall, 1);
    check("unlk_prio", prio_o, 1);
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Host writes 624 to addr 10, CPU reads it back
    tick(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd10; dbg_wdata = 16'd624; #1;
    check("wr_dbg_gnt", dbg_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 10);
    check("wr_mem_wdata", mem_wdata, 624);
    tick(); dbg_req = 1'b0; dbg_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd10; #1;
    check("wr_no_rvalid", dbg_rvalid, 0);
    check("wr_rd_cpu_gnt", cpu_gnt, 1);
    check("wr_rd_mem_we", mem_we, 0);
    tick(); cpu_req = 1'b0; #1;
    check("wr_rd_cpu_rvalid", cpu_rvalid, 1);
    check("wr_rd_cpu_rdata", cpu_rdata, 624);
    check("wr_rd_mem_we_idle", mem_we, 0);

    // Reset pulse while a CPU read is granted
    tick(); cpu_req = 1'b1; cpu_addr = 8'd51; #1;
    check("rr_rst_cpu_gnt", cpu_gnt, 1);
    #1 rst = 1'b1; #1;
    check("rr_rst_gnt_forced", cpu_gnt, 0);
    check("rr_rst_mem_en", mem_en, 0);
    check("rr_rst_cpu_rdata", cpu_rdata, 0);
    #1 cpu_req = 1'b0; rst = 1'b0;
    tick(); #1;
    check("rr_post_cpu_rvalid", cpu_rvalid, 0);
    check("rr_post_rd_owner", rd_owner_o, 0);
    check("rr_post_prio", prio_o, 0);
    tick(); #1;
    check("rr_post2_cpu_rvalid", cpu_rvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
